// File: rtl/icetap_capture_ctrl.sv
// Logic-analyser capture controller: qualifies probed signals, writes samples to a
// circular capture RAM around a trigger. Optional macro ICETAP_TRIGGER_EDGE_EN enables change-trigger.
module icetap_capture_ctrl #(
  parameter int NR_SIGNALS    = 16,
  parameter int RAM_ADDR_BITS = 8
) (
  input  logic                       clk,
  input  logic                       reset_,
  input  logic [NR_SIGNALS-1:0]      signals_in,
  input  logic                       cmd_valid,
  input  logic [1:0]                 cmd,
  input  logic [3*NR_SIGNALS-1:0]    store_mask,
  input  logic [3*NR_SIGNALS-1:0]    trigger_mask,
  input  logic [RAM_ADDR_BITS-1:0]   pretrig_depth,
  output logic                       mem_wr,
  output logic [RAM_ADDR_BITS-1:0]   mem_addr,
  output logic [NR_SIGNALS-1:0]      mem_wdata,
  output logic [2:0]                 state,
  output logic [RAM_ADDR_BITS-1:0]   trigger_addr,
  output logic                       done
);

  localparam int A = RAM_ADDR_BITS;
  localparam logic [A-1:0] ONE_A = 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [NR_SIGNALS-1:0]   sig_d_q, sig_dd_q, chg;
  logic [A-1:0]            wr_ptr_q, wr_ptr_d;
  logic [A-1:0]            cnt_q, cnt_d;
  logic [A-1:0]            trig_addr_q, trig_addr_d;
  logic [A-1:0]            mem_addr_q, mem_addr_d;
  logic [NR_SIGNALS-1:0]   mem_wdata_q, mem_wdata_d;
  logic                    mem_wr_q, mem_wr_d;
  logic                    wr_en;
  logic [3*NR_SIGNALS-1:0] trig_m;
  logic [NR_SIGNALS-1:0]   store_term, trig_term;
  logic                    store_hit, trig_hit;
  logic [A:0]              cnt_inc;
  logic [A-1:0]            post_len;

  assign chg      = sig_d_q ^ sig_dd_q;
  assign cnt_inc  = {1'b0, cnt_q} + {1'b0, ONE_A};
  // Samples after the trigger: D-1-pretrig_depth, i.e. the bitwise complement.
  assign post_len = ~pretrig_depth;

`ifdef ICETAP_TRIGGER_EDGE_EN
  assign trig_m = trigger_mask;
`else
  assign trig_m = trigger_mask & {NR_SIGNALS{3'b011}};
`endif

  always_comb begin
    store_term = '0;
    trig_term  = '0;
    for (int i = 0; i < NR_SIGNALS; i++) begin
      store_term[i] = (store_mask[3*i]   &  sig_d_q[i]) |
                      (store_mask[3*i+1] & ~sig_d_q[i]) |
                      (store_mask[3*i+2] &  chg[i]);
      trig_term[i]  = (trig_m[3*i +: 3] == 3'b000)   |
                      (trig_m[3*i]   &  sig_d_q[i])  |
                      (trig_m[3*i+1] & ~sig_d_q[i])  |
                      (trig_m[3*i+2] &  chg[i]);
    end
    store_hit = (store_mask == '0) | (|store_term);
    trig_hit  = &trig_term;
  end

  // cmd_valid is a single-cycle strobe with no back-pressure; cmd is ignored when it is low.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    trig_addr_d = trig_addr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wr_en       = 1'b0;
    if (cmd_valid && cmd == 2'd1) begin
      state_d  = (pretrig_depth != '0) ? S_PRE : S_ARMED;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else if (cmd_valid && cmd == 2'd2) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_PRE: begin
          if (store_hit) begin
            wr_en = 1'b1;
            if (cnt_inc >= {1'b0, pretrig_depth}) begin
              state_d = S_ARMED;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc[A-1:0];
            end
          end
        end
        S_ARMED: begin
          if (trig_hit) begin
            wr_en       = 1'b1;
            trig_addr_d = wr_ptr_q;
            cnt_d       = '0;
            state_d     = (post_len == '0) ? S_DONE : S_POST;
          end else if (store_hit) begin
            wr_en = 1'b1;
          end
        end
        S_POST: begin
          if (store_hit) begin
            wr_en = 1'b1;
            if (cnt_inc >= {1'b0, post_len}) begin
              state_d = S_DONE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc[A-1:0];
            end
          end
        end
        S_IDLE, S_DONE: begin
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (wr_en) begin
      wr_ptr_d    = wr_ptr_q + ONE_A;
      mem_addr_d  = wr_ptr_q;
      mem_wdata_d = sig_d_q;
    end
    mem_wr_d = wr_en;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q     <= S_IDLE;
      sig_d_q     <= '0;
      sig_dd_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      trig_addr_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sig_d_q     <= signals_in;
      sig_dd_q    <= sig_d_q;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      trig_addr_q <= trig_addr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wr_q    <= mem_wr_d;
    end
  end

  assign state        = state_q;
  assign done         = (state_q == S_DONE);
  assign mem_wr       = mem_wr_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign trigger_addr = trig_addr_q;

endmodule

// File: tb/tb_icetap_capture_ctrl.sv
// Bench for icetap_capture_ctrl: directed scenarios plus random traffic against a
// sample-sequence reference model of the capture rules.
module tb_icetap_capture_ctrl;
  localparam int NS = 16;
  localparam int AB = 4;
  localparam int D  = 16;

  logic              clk;
  logic              reset_;
  logic [NS-1:0]     signals_in;
  logic              cmd_valid;
  logic [1:0]        cmd;
  logic [3*NS-1:0]   store_mask;
  logic [3*NS-1:0]   trigger_mask;
  logic [AB-1:0]     pretrig_depth;
  logic              mem_wr;
  logic [AB-1:0]     mem_addr;
  logic [NS-1:0]     mem_wdata;
  logic [2:0]        state;
  logic [AB-1:0]     trigger_addr;
  logic              done;

  icetap_capture_ctrl #(.NR_SIGNALS(NS), .RAM_ADDR_BITS(AB)) dut (
    .clk(clk), .reset_(reset_), .signals_in(signals_in), .cmd_valid(cmd_valid),
    .cmd(cmd), .store_mask(store_mask), .trigger_mask(trigger_mask),
    .pretrig_depth(pretrig_depth), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .state(state), .trigger_addr(trigger_addr), .done(done)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  logic [AB+NS-1:0] exp_q[$];
  logic [NS-1:0]    ram [D];
  int               n_wr;
  logic [15:0]      ctr;

  // reference model: phase 0 idle, 1 pre, 2 armed, 3 post, 4 done
  int            m_ph, m_ptr, m_pre_left, m_post_left;
  logic [AB-1:0] m_taddr;
  logic [NS-1:0] m_sig_d, m_sig_dd;
  logic          m_wr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic store_ok(input logic [NS-1:0] d, input logic [NS-1:0] dd,
                                    input logic [3*NS-1:0] msk);
    logic [2:0] m;
    if (msk == '0) return 1'b1;
    for (int i = 0; i < NS; i++) begin
      m = msk[3*i +: 3];
      if ((m[0] && d[i]) || (m[1] && !d[i]) || (m[2] && d[i] != dd[i])) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic trig_ok(input logic [NS-1:0] d, input logic [NS-1:0] dd,
                                   input logic [3*NS-1:0] msk);
    logic [2:0] m;
    for (int i = 0; i < NS; i++) begin
      m = msk[3*i +: 3];
`ifndef ICETAP_TRIGGER_EDGE_EN
      m[2] = 1'b0;
`endif
      if (m == 3'b000) continue;
      if (!((m[0] && d[i]) || (m[1] && !d[i]) || (m[2] && d[i] != dd[i]))) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_ptr = 0; m_pre_left = 0; m_post_left = 0;
    m_taddr = '0; m_sig_d = '0; m_sig_dd = '0; m_wr = 1'b0;
    exp_q.delete();
  endtask

  task automatic m_write();
    exp_q.push_back({m_ptr[AB-1:0], m_sig_d});
    m_ptr = (m_ptr + 1) % D;
    m_wr  = 1'b1;
  endtask

  task automatic model_edge();
    m_wr = 1'b0;
    if (!reset_) begin
      model_reset();
      return;
    end
    if (cmd_valid && cmd == 2'd1) begin
      m_ph = (pretrig_depth != 0) ? 1 : 2;
      m_ptr = 0;
      m_pre_left = int'(pretrig_depth);
    end else if (cmd_valid && cmd == 2'd2) begin
      m_ph = 0;
    end else begin
      case (m_ph)
        1: if (store_ok(m_sig_d, m_sig_dd, store_mask)) begin
             m_write();
             m_pre_left--;
             if (m_pre_left <= 0) m_ph = 2;
           end
        2: if (trig_ok(m_sig_d, m_sig_dd, trigger_mask)) begin
             m_taddr = m_ptr[AB-1:0];
             m_write();
             m_post_left = D - 1 - int'(pretrig_depth);
             m_ph = (m_post_left == 0) ? 4 : 3;
           end else if (store_ok(m_sig_d, m_sig_dd, store_mask)) begin
             m_write();
           end
        3: if (store_ok(m_sig_d, m_sig_dd, store_mask)) begin
             m_write();
             m_post_left--;
             if (m_post_left == 0) m_ph = 4;
           end
        default: ;
      endcase
    end
    m_sig_dd = m_sig_d;
    m_sig_d  = signals_in;
  endtask

  // one clock: model step on the edge, scoreboard compare 1ns later, return at negedge
  task automatic cyc();
    logic [AB+NS-1:0] e;
    @(posedge clk);
    model_edge();
    #1;
    check("mem_wr", 32'(mem_wr), 32'(m_wr));
    if (m_wr) begin
      e = exp_q.pop_front();
      check("wr_addr", 32'(mem_addr), 32'(e[AB+NS-1:NS]));
      check("wr_data", 32'(mem_wdata), 32'(e[NS-1:0]));
    end
    check("state", 32'(state), 32'(m_ph));
    check("done", 32'(done), 32'(m_ph == 4));
    check("trigger_addr", 32'(trigger_addr), 32'(m_taddr));
    if (mem_wr) begin
      ram[mem_addr] = mem_wdata;
      n_wr++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd = 2'd0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      signals_in = ctr;
      cyc();
      ctr++;
    end
  endtask

  task automatic issue(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd = c;
    signals_in = ctr;
    cyc();
    ctr++;
  endtask

  initial begin
    reset_ = 1'b0; signals_in = '0; cmd_valid = 1'b0; cmd = 2'd0;
    store_mask = '0; trigger_mask = '0; pretrig_depth = '0;
    ctr = '0; n_wr = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_trigger_addr", 32'(trigger_addr), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset_ = 1'b1;
    run(3);

    // basic capture: 4 pre, immediate trigger, 11 post
    pretrig_depth = 4'd4; ctr = '0; n_wr = 0;
    issue(2'd1);
    run(20);
    check("basic_trig_addr", 32'(trigger_addr), 32'd4);
    check("basic_nwr", 32'(n_wr), 32'd16);
    check("basic_done", 32'(done), 32'd1);
    check("basic_ram4", 32'(ram[4]), 32'd4);

    // abort in POST after 3 writes, then restart from address 0
    ctr = '0;
    issue(2'd1);
    run(8);
    issue(2'd2);
    check("abort_state", 32'(state), 32'd0);
    check("abort_mem_wr", 32'(mem_wr), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    issue(2'd1);
    run(1);
    check("restart_wr", 32'(mem_wr), 32'd1);
    check("restart_addr", 32'(mem_addr), 32'd0);
    run(20);

    // odd-only storage, trigger never matches, address wraps
    store_mask = '0; store_mask[2:0] = 3'b001;
    trigger_mask = '0; trigger_mask[47:45] = 3'b001;
    pretrig_depth = '0; ctr = '0; n_wr = 0;
    issue(2'd1);
    run(40);
    check("odd_state", 32'(state), 32'd2);
    check("odd_nwr", 32'(n_wr), 32'd20);
    for (int i = 0; i < D; i++) check("odd_ram_lsb", 32'(ram[i][0]), 32'd1);

    // level trigger on 16'h1c00 with 8 pre-trigger samples
    store_mask = '0;
    for (int i = 0; i < NS; i++)
      trigger_mask[3*i +: 3] = (i >= 10 && i <= 12) ? 3'b001 : 3'b010;
    pretrig_depth = 4'd8; ctr = '0;
    issue(2'd1);
    for (int k = 0; k < 8000 && m_ph != 4; k++) run(1);
    check("lvl_done", 32'(done), 32'd1);
    check("lvl_trig_sample", 32'(ram[trigger_addr]), 32'h1c00);
    run(5);
    check("lvl_wr_after_done", 32'(mem_wr), 32'd0);

    // change trigger on bit15
    trigger_mask = '0; trigger_mask[47:45] = 3'b100;
    pretrig_depth = '0; ctr = 16'h7fd0;
    run(4);
    issue(2'd1);
    for (int k = 0; k < 200 && m_ph != 4; k++) run(1);
    check("edge_done", 32'(done), 32'd1);
`ifdef ICETAP_TRIGGER_EDGE_EN
    check("edge_trig_sample", 32'(ram[trigger_addr]), 32'h8000);
`else
    check("edge_trig_sample", 32'(ram[trigger_addr]), 32'h7fd4);
`endif

    // asynchronous reset while ARMED
    trigger_mask = '0; trigger_mask[47:45] = 3'b001;
    ctr = '0;
    issue(2'd1);
    run(5);
    check("armed_state", 32'(state), 32'd2);
    #2 reset_ = 1'b0;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_mem_wr", 32'(mem_wr), 32'd0);
    check("arst_mem_addr", 32'(mem_addr), 32'd0);
    check("arst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("arst_trigger_addr", 32'(trigger_addr), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    model_reset();
    run(2);
    reset_ = 1'b1;
    n_wr = 0;
    run(20);
    check("arst_nwr", 32'(n_wr), 32'd0);
    check("arst_idle", 32'(state), 32'd0);

    // random traffic
    pretrig_depth = 4'($urandom_range(0, D - 1));
    issue(2'd1);
    for (int k = 0; k < 3000; k++) begin
      int r;
      if (k % 64 == 0) begin
        store_mask = '0;
        trigger_mask = '0;
        if ($urandom_range(0, 3) != 0)
          for (int i = 0; i < NS; i++)
            if ($urandom_range(0, 3) == 0) store_mask[3*i +: 3] = 3'($urandom_range(0, 7));
        for (int i = 0; i < NS; i++)
          if ($urandom_range(0, 7) == 0) trigger_mask[3*i +: 3] = 3'($urandom_range(0, 7));
      end
      r = int'($urandom_range(0, 199));
      if (r < 3) begin
        pretrig_depth = 4'($urandom_range(0, D - 1));
        cmd_valid = 1'b1; cmd = 2'd1;
      end else if (r < 4) begin
        cmd_valid = 1'b1; cmd = 2'd2;
      end else if (r < 6) begin
        cmd_valid = 1'b1; cmd = (r == 4) ? 2'd0 : 2'd3;
      end
      signals_in = NS'($urandom);
      cyc();
    end
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
